// File: rtl/fpw_pkg.sv
// rtl/fpw_pkg.sv - shared constants, operand type and FSM encoding for fp16_result_writer
package fpw_pkg;

   localparam int UNI_BIAS     = 25;
   localparam int FP16_BIAS    = 15;
   localparam int UNI_MAN_W    = 22;
   localparam int UNI_EXP_W    = 6;
   localparam int FP16_EXP_MAX = 31;

   typedef struct packed {
      logic                 sgn;
      logic [UNI_EXP_W-1:0] exp;
      logic [UNI_MAN_W-1:0] man_dn;
   } uni_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } wr_state_e;

endpackage

// File: rtl/lzc22.sv
// rtl/lzc22.sv - combinational leading-one position encoder for a 22-bit mantissa
module lzc22 (
   input  logic [21:0] din,
   output logic [4:0]  pos,
   output logic        zero
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      pos = '0;
      for (int i = 0; i < 22; i++) begin
         if (din[i]) begin
            pos = 5'(i);
         end
      end
   end

   assign zero = ~|din;

endmodule

// File: rtl/fp16_result_writer.sv
// rtl/fp16_result_writer.sv - unified FPALU result to FP16 burst writer; FPW_ROUND_NEAREST_EN selects RNE, else truncation
module fp16_result_writer
   import fpw_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [8:0]  len,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        din_uni_y_sgn,
   input  logic [5:0]  din_uni_y_exp,
   input  logic [21:0] din_uni_y_man_dn,
   output logic        mem_we,
   output logic [8:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        done,
   output logic        flag_ovf,
   output logic        flag_unf
);

   wr_state_e   state_q, state_d;
   logic [8:0]  len_q, len_d;
   logic [8:0]  acc_cnt_q, acc_cnt_d;
   logic [8:0]  wr_cnt_q, wr_cnt_d;
   logic        s1_valid_q, s1_valid_d;
   uni_t        s1_op_q, s1_op_d;
   logic [4:0]  s1_pos_q, s1_pos_d;
   logic        s1_zero_q, s1_zero_d;
   logic        mem_we_q, mem_we_d;
   logic [8:0]  mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;

   uni_t        din_op;
   logic [4:0]  lzc_pos;
   logic        lzc_zero;
   logic        xfer;
   logic        last_wr;

   logic [21:0] s2_shifted;
   logic [9:0]  s2_mant;
   logic        s2_inc;
   logic [10:0] s2_mant_r;
   int          s2_exp;
   logic [15:0] s2_word;
   logic        s2_ovf;
   logic        s2_unf;

   assign din_op = {din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn};

   lzc22 u_lzc (
      .din  (din_op.man_dn),
      .pos  (lzc_pos),
      .zero (lzc_zero)
   );

   assign xfer    = in_valid && in_ready;
   assign last_wr = mem_we_q && (mem_addr_q == len_q - 9'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = (len == 9'd0) ? ST_DONE : ST_BUSY;
      end else if (state_q == ST_BUSY && last_wr) begin
         state_d = ST_DONE;
      end
   end

   // A start cycle never accepts data, so nothing from the old burst leaks in.
   always_comb begin
      in_ready = (state_q == ST_BUSY) && (acc_cnt_q < len_q) && !start;
      done     = (state_q == ST_DONE);
   end

   // Stage 2: align the leading one to bit 21, then round and pack.
   always_comb begin
      s2_shifted = s1_op_q.man_dn << (5'(UNI_MAN_W - 1) - s1_pos_q);
      s2_mant    = 10'(s2_shifted >> 11);
`ifdef FPW_ROUND_NEAREST_EN
      s2_inc     = s2_shifted[10] & ((|s2_shifted[9:0]) | s2_mant[0]);
`else
      s2_inc     = 1'b0;
`endif
      s2_mant_r  = {1'b0, s2_mant} + {10'd0, s2_inc};
      s2_exp     = int'(s1_op_q.exp) - UNI_BIAS + FP16_BIAS - (UNI_MAN_W - 1)
                 + int'(s1_pos_q) + int'(s2_mant_r[10]);
      s2_ovf     = 1'b0;
      s2_unf     = 1'b0;
      if (s1_zero_q) begin
         s2_word = {s1_op_q.sgn, 15'd0};
      end else if (s2_exp >= FP16_EXP_MAX) begin
         s2_word = {s1_op_q.sgn, 5'h1F, 10'd0};
         s2_ovf  = 1'b1;
      end else if (s2_exp <= 0) begin
         s2_word = {s1_op_q.sgn, 15'd0};
         s2_unf  = 1'b1;
      end else begin
         s2_word = {s1_op_q.sgn, 5'(s2_exp), s2_mant_r[9:0]};
      end
   end

   always_comb begin
      len_d       = len_q;
      acc_cnt_d   = acc_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_pos_d    = s1_pos_q;
      s1_zero_d   = s1_zero_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      if (start) begin
         len_d      = len;
         acc_cnt_d  = '0;
         wr_cnt_d   = '0;
         s1_valid_d = 1'b0;
         mem_we_d   = 1'b0;
         mem_addr_d = '0;
         ovf_d      = 1'b0;
         unf_d      = 1'b0;
      end else begin
         s1_valid_d = xfer;
         if (xfer) begin
            s1_op_d   = din_op;
            s1_pos_d  = lzc_pos;
            s1_zero_d = lzc_zero;
            acc_cnt_d = acc_cnt_q + 9'd1;
         end
         mem_we_d = s1_valid_q;
         if (s1_valid_q) begin
            mem_addr_d  = wr_cnt_q;
            wr_cnt_d    = wr_cnt_q + 9'd1;
            mem_wdata_d = s2_word;
            ovf_d       = ovf_q | s2_ovf;
            unf_d       = unf_q | s2_unf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q       <= '0;
         acc_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_pos_q    <= '0;
         s1_zero_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         len_q       <= len_d;
         acc_cnt_q   <= acc_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_pos_q    <= s1_pos_d;
         s1_zero_q   <= s1_zero_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign flag_ovf  = ovf_q;
   assign flag_unf  = unf_q;

endmodule

// File: doc/fp16_result_writer.md
FP16_RESULT_WRITER -- requirements
Module: fp16_result_writer

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that arms a burst.
REQ-004 SHALL have port len, input, 9, number of results in the burst, sampled on start; 0 means no writes.
REQ-005 SHALL have port in_valid, input, 1, a unified-format result is presented.
REQ-006 SHALL have port in_ready, output, 1, the block accepts the result this cycle.
REQ-007 SHALL have ports din_uni_y_sgn (input, 1), din_uni_y_exp (input, 6) and din_uni_y_man_dn (input, 22), the unified-format FPALU result.
REQ-008 SHALL have ports mem_we (output, 1), mem_addr (output, 9) and mem_wdata (output, 16), the result-memory write port.
REQ-009 SHALL have port done, output, 1, level high once the burst is complete.
REQ-010 SHALL have ports flag_ovf and flag_unf, outputs, 1 each, sticky overflow and underflow flags.

Function
REQ-011 SHALL interpret the unified value as (-1)^sgn * man_dn/2^21 * 2^(exp-25); man_dn may carry leading zeros (denormalised).
REQ-012 SHALL define a transfer as a cycle with in_valid=1 and in_ready=1.
REQ-013 SHALL drive in_ready=1 only while busy and accepted-count < len.
REQ-014 SHALL use a 2-stage pipeline:
  - stage 1 registers the operand and the leading-one position p;
  - stage 2 normalises, rounds and packs.
REQ-015 SHALL assert mem_we exactly 2 cycles after each transfer, one result per cycle, back-to-back sustained.
REQ-016 SHALL compute the FP16 exponent as E = exp - (21-p) - 10; mantissa = the 10 bits below the leading one; guard = next bit; sticky = OR of the remaining bits.
REQ-017 SHALL pack man_dn==0 as signed zero (sgn,15'b0).
REQ-018 SHALL pack E>=31 after rounding as signed infinity (exponent field 5'h1F, mantissa 0) and set flag_ovf.
REQ-019 SHALL pack E<=0 as flush-to-signed-zero and set flag_unf; no FP16 subnormals are produced.
REQ-020 SHALL propagate a rounding carry out of the mantissa into E, re-checking the overflow condition.
REQ-021 SHALL drive mem_addr from 0 for the first write of a burst, incrementing by 1 per write.
REQ-022 SHALL raise done the cycle after the last write of the burst, or the cycle after start when len=0; done stays high until the next start.
REQ-023 SHALL handle start at any time, including mid-burst:
  - clear the counters, done and the flags;
  - discard in-flight pipeline entries (no mem_we for them);
  - sample the new len.
REQ-024 SHALL drive mem_we=0 whenever not busy.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, clear all of: busy, counters, pipeline valids, in_ready, mem_we, mem_addr, mem_wdata, done, flag_ovf and flag_unf (all to 0).
REQ-026 SHALL, when reset is asserted mid-burst, abandon the burst with no further writes.

Configuration
REQ-027 SHALL use macro FPW_ROUND_NEAREST_EN: when defined, round-to-nearest-even (increment if guard & (sticky | mantissa LSB)).
REQ-028 SHALL, when FPW_ROUND_NEAREST_EN is undefined, truncate (guard and sticky ignored); latency is unchanged in both modes.

Structure
REQ-029 SHALL place the following in shared package fpw_pkg:
  - constants UNI_BIAS=25, FP16_BIAS=15, UNI_MAN_W=22, UNI_EXP_W=6, FP16_EXP_MAX=31;
  - a typedef for the unified operand.
REQ-030 SHALL instantiate one sub-module, lzc22: a combinational 22-bit leading-one position encoder used in stage 1.

Verification
REQ-031 SHALL cover: start len=1, input sgn0 exp=25 man=0x200000 -> mem_we at transfer+2, addr 0, wdata 0x3C00, done next cycle.
REQ-032 SHALL cover: sgn1 exp=26 man=0x300000 -> 0xC200; denormalised sgn0 exp=35 man=0x080000 -> 0x5C00 (256.0).
REQ-033 SHALL cover: exp=25 man=0x200C00 -> 0x3C02 with FPW_ROUND_NEAREST_EN, 0x3C01 without; man=0x200400 -> 0x3C00 in both modes.
REQ-034 SHALL cover: exp=50 man=0x200000 -> 0x7C00 with flag_ovf=1; exp=5 man=0x200000 -> 0x0000 with flag_unf=1; both flags hold until the next start.
REQ-035 SHALL cover: len=4 with in_valid held high -> four consecutive writes at addr 0..3, in_ready low after the 4th transfer; start during the 3rd write -> no further writes, and a new burst begins at addr 0.
REQ-036 SHALL cover: len=0 -> done the cycle after start, no mem_we; rst_n low mid-burst -> all outputs 0 on the next edge.
